// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the mem_access_ctrl slice: access-size encodings and FSM states.
// Optional misaligned-access trapping is enabled with the MISALIGN_TRAP_EN macro.
package mem_access_ctrl_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables and data replication, load lane shift and extension.
// Low address bits below the access size are ignored here; trapping is decided by the caller.
module mem_lane_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [1:0]  wr_size,
    input  logic [1:0]  wr_off,
    input  logic [31:0] wr_data,
    output logic [3:0]  wr_be,
    output logic [31:0] wr_din,
    input  logic [1:0]  rd_size,
    input  logic [1:0]  rd_off,
    input  logic        rd_unsigned,
    input  logic [31:0] rd_word,
    output logic [31:0] rd_data
);

    logic [31:0] shifted;

    always_comb begin
        wr_be  = '0;
        wr_din = wr_data;
        case (wr_size)
            SIZE_BYTE: begin
                wr_be  = 4'b0001 << wr_off;
                wr_din = {4{wr_data[7:0]}};
            end
            SIZE_HALF: begin
                wr_be  = 4'b0011 << {wr_off[1], 1'b0};
                wr_din = {2{wr_data[15:0]}};
            end
            SIZE_WORD: wr_be = 4'b1111;
            default:   wr_be = '0;
        endcase
    end

    always_comb begin
        shifted = rd_word;
        rd_data = rd_word;
        case (rd_size)
            SIZE_BYTE: begin
                shifted = rd_word >> {rd_off, 3'b000};
                rd_data = rd_unsigned ? {24'h0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
            end
            SIZE_HALF: begin
                shifted = rd_word >> {rd_off[1], 4'b0000};
                rd_data = rd_unsigned ? {16'h0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
            end
            default: rd_data = rd_word;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store controller in front of a synchronous 32-bit RAM.
// Define MISALIGN_TRAP_EN to reject misaligned half/word accesses with rsp_err.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clka,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_din,
    output logic [3:0]            ram_we,
    input  logic [31:0]           ram_dout
);

    state_t      state;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        accept;
    logic        misalign;
    logic        req_err;
    logic [3:0]  lane_be;
    logic [31:0] load_data;

    mem_lane_align u_align (
        .wr_size     (req_size),
        .wr_off      (req_addr[1:0]),
        .wr_data     (req_wdata),
        .wr_be       (lane_be),
        .wr_din      (ram_din),
        .rd_size     (size_q),
        .rd_off      (off_q),
        .rd_unsigned (uns_q),
        .rd_word     (ram_dout),
        .rd_data     (load_data)
    );

`ifdef MISALIGN_TRAP_EN
    assign misalign = ((req_size == SIZE_HALF) && req_addr[0]) ||
                      ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign req_err   = (req_size == SIZE_ILL) || misalign;
    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign ram_addr  = req_addr[ADDR_WIDTH+1:2];
    // rst gates the write strobe directly so no write slips through while reset is held
    assign ram_we    = (accept && req_we && !req_err && !rst) ? lane_be : '0;

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            off_q     <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (req_err || req_we) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= req_err;
                            rsp_rdata <= '0;
                            state     <= RESP;
                        end else begin
                            off_q  <= req_addr[1:0];
                            size_q <= req_size;
                            uns_q  <= req_unsigned;
                            state  <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    rsp_rdata <= load_data;
                    rsp_err   <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: byte-array reference model, queued expectations, response monitor.
// Honours MISALIGN_TRAP_EN the same way the design does.
module tb_mem_access_ctrl;

    localparam int AW = 8;

    logic          clka = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW+1:0] req_addr;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_din;
    logic [3:0]    ram_we;
    logic [31:0]   ram_dout;

    mem_access_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clka(clka), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
    );

    always #5 clka = ~clka;

    // Synchronous RAM: read data one clka after the address
    logic [31:0] ram_mem [0:(1<<AW)-1];
    always @(posedge clka) begin
        for (int b = 0; b < 4; b++)
            if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
        ram_dout <= ram_mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clka) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  mem_m [0:(4<<AW)-1];
    int          checks = 0;
    int          errors = 0;
    int          stall_n = 0;
    bit          active = 0;
    bit          hs = 0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model in byte-addressed terms
    task automatic model(input logic we, input int a, input logic [1:0] sz, input logic uns,
                         input logic [31:0] wd, output logic [31:0] data, output logic err,
                         output logic [3:0] be, output int lat);
        int  n;
        int  base;
        bit  legal;
        legal = (sz != 2'b11);
`ifdef MISALIGN_TRAP_EN
        if (sz == 2'b01 && (a % 2) != 0) legal = 0;
        if (sz == 2'b10 && (a % 4) != 0) legal = 0;
`endif
        data = '0;
        be   = '0;
        err  = !legal;
        lat  = (we || !legal) ? 1 : 2;
        if (legal) begin
            n    = 1 << sz;
            base = a - (a % n);
            for (int i = 0; i < n; i++) begin
                if (we) begin
                    mem_m[base+i] = wd[8*i +: 8];
                    be[(base+i) % 4] = 1'b1;
                end else begin
                    data = data | (32'(mem_m[base+i]) << (8*i));
                end
            end
            if (!we && !uns && n < 4 && data[8*n-1])
                data = data | (32'hFFFF_FFFF << (8*n));
        end
    endtask

    task automatic issue(input logic we, input int a, input logic [1:0] sz, input logic uns,
                         input logic [31:0] wd);
        int         waitc;
        exp_t       e;
        logic [3:0] be;
        waitc = 0;
        @(negedge clka);
        while (!req_ready) begin
            waitc++;
            if (waitc > 50) begin
                chk(1'b0, "req_ready_timeout", 32'(req_ready), 32'd1);
                return;
            end
            @(negedge clka);
        end
        model(we, a, sz, uns, wd, e.data, e.err, be, e.lat);
        e.acc        = cyc;
        req_we       = we;
        req_addr     = (AW+2)'(a);
        req_size     = sz;
        req_unsigned = uns;
        req_wdata    = wd;
        req_valid    = 1'b1;
        q.push_back(e);
        #1 chk(ram_we == be, "ram_we_accept", 32'(ram_we), 32'(be));
        @(posedge clka);
        #1 req_valid = 1'b0;
    endtask

    // Response monitor
    initial begin
        exp_t cur;
        int   stall;
        stall = 0;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clka);
            if (rst) begin
                active = 0;
                hs = 0;
            end else begin
                if (hs) begin
                    chk(!rsp_valid && req_ready, "handshake_done",
                        {30'h0, rsp_valid, req_ready}, 32'd1);
                    hs = 0;
                end else if (rsp_valid) begin
                    if (!active) begin
                        if (q.size() == 0) begin
                            chk(1'b0, "unexpected_rsp", rsp_rdata, 32'h0);
                            cur.data = rsp_rdata;
                            cur.err  = rsp_err;
                        end else begin
                            cur = q.pop_front();
                            chk(rsp_rdata == cur.data, "rsp_rdata", rsp_rdata, cur.data);
                            chk(rsp_err == cur.err, "rsp_err", 32'(rsp_err), 32'(cur.err));
                            chk(cyc == cur.acc + cur.lat, "latency", cyc, cur.acc + cur.lat);
                        end
                        active = 1;
                        stall = stall_n;
                        stall_n = 0;
                    end else begin
                        chk(rsp_rdata == cur.data && rsp_err == cur.err, "rsp_stable",
                            rsp_rdata, cur.data);
                    end
                    chk(!req_ready && ram_we == 4'b0, "busy_no_accept",
                        {27'h0, req_ready, ram_we}, 32'h0);
                    if (stall > 0) begin
                        rsp_ready = 1'b0;
                        stall--;
                    end else begin
                        rsp_ready = ($urandom % 4) != 0;
                    end
                    if (rsp_ready) begin
                        hs = 1;
                        active = 0;
                    end
                end else begin
                    rsp_ready = $urandom % 2;
                end
            end
        end
    end

    initial begin
        int t;
        for (int i = 0; i < (1<<AW); i++) ram_mem[i] = '0;
        for (int i = 0; i < (4<<AW); i++) mem_m[i] = '0;
        rst = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = '0;
        req_size = '0;
        req_unsigned = 1'b0;
        req_wdata = '0;
        #12;
        chk(!rsp_valid && rsp_rdata == 0 && !rsp_err, "reset_rsp", rsp_rdata, 32'h0);
        chk(req_ready && ram_we == 0, "reset_ready", {27'h0, req_ready, ram_we}, 32'h10);
        @(posedge clka);
        #3 rst = 1'b0;

        // Directed scenarios
        issue(1'b1, 'h10, 2'b10, 1'b0, 32'hDEAD_BEEF);
        issue(1'b0, 'h10, 2'b10, 1'b0, 32'h0);
        issue(1'b1, 'h13, 2'b00, 1'b0, 32'h0000_0080);
        issue(1'b0, 'h13, 2'b00, 1'b0, 32'h0);
        issue(1'b0, 'h13, 2'b00, 1'b1, 32'h0);
        issue(1'b1, 'h10, 2'b10, 1'b0, 32'h8001_1234);
        issue(1'b0, 'h12, 2'b01, 1'b0, 32'h0);
        issue(1'b0, 'h12, 2'b01, 1'b1, 32'h0);
        issue(1'b0, 'h11, 2'b10, 1'b0, 32'h0);
        issue(1'b1, 'h11, 2'b10, 1'b0, 32'h5555_AAAA);
        issue(1'b0, 'h10, 2'b10, 1'b0, 32'h0);
        issue(1'b1, 'h20, 2'b11, 1'b0, 32'hFFFF_FFFF);
        stall_n = 5;
        issue(1'b0, 'h10, 2'b10, 1'b0, 32'h0);

        // Reset while the load is waiting on RAM data
        issue(1'b0, 'h10, 2'b10, 1'b0, 32'h0);
        #1 rst = 1'b1;
        #1 chk(!rsp_valid && ram_we == 0, "rst_rd_wait", {27'h0, rsp_valid, ram_we}, 32'h0);
        q.delete();
        @(posedge clka);
        #3 rst = 1'b0;
        repeat (3) begin
            @(negedge clka);
            chk(req_ready && !rsp_valid, "post_rst_idle", {30'h0, req_ready, rsp_valid}, 32'h2);
        end

        // Randomized traffic over a small window so loads hit earlier stores
        for (int n = 0; n < 250; n++) begin
            logic [1:0] sz;
            sz = ($urandom % 8 == 0) ? 2'b11 : 2'($urandom % 3);
            issue(1'($urandom % 2), int'($urandom_range(0, 63)), sz, 1'($urandom % 2), $urandom);
        end

        t = 0;
        while ((q.size() != 0 || rsp_valid) && t < 200) begin
            @(negedge clka);
            t++;
        end
        if (t >= 200) chk(1'b0, "drain_timeout", 32'(q.size()), 32'h0);
        repeat (2) @(negedge clka);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, giving the RAM word-address width; the byte address is ADDR_WIDTH+2 bits.
REQ-002 SHALL have ports, clock and reset first:
- clka  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_WIDTH+2  byte address
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  zero-extend load data (else sign-extend)
- req_wdata  in  32  store data, LSB-aligned
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  32  aligned, extended load data; 0 for stores and errors
- rsp_err  out  1  access rejected
- ram_addr  out  ADDR_WIDTH  RAM word address
- ram_din  out  32  RAM write data
- ram_we  out  4  RAM byte write enables
- ram_dout  in  32  RAM read data, valid one clka after the address

Function
REQ-003 SHALL implement states IDLE, RD_WAIT, RESP; req_ready = 1 only in IDLE.
REQ-004 A request SHALL be accepted on a clka edge with req_valid && req_ready.
REQ-005 ram_addr SHALL equal req_addr[ADDR_WIDTH+1:2] combinationally in IDLE.
REQ-006 ram_we SHALL be non-zero only in the accept cycle of a legal store; it is 4'b0000 in every other cycle.
REQ-007 Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
REQ-008 ram_din: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-009 Store: IDLE->RESP on accept; rsp_valid high the next cycle, rsp_rdata = 0, rsp_err = 0.
REQ-010 Load: IDLE->RD_WAIT on accept; offset, size and unsigned are latched.
REQ-011 In RD_WAIT, the selected lane of ram_dout SHALL be shifted to bit 0, then sign- or zero-extended and registered into rsp_rdata; the FSM then goes to RESP. Load response latency is 2 cycles from accept.
REQ-012 RESP SHALL hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready; on rsp_valid && rsp_ready it returns to IDLE. No new request is accepted in that same cycle.
REQ-013 req_size = 11 SHALL cause no RAM write and a 1-cycle response with rsp_err = 1, rsp_rdata = 0.
REQ-014 A request SHALL see all earlier accepted stores (no read-before-write hazard), because only one transaction is in flight.

Reset
REQ-015 rst high SHALL asynchronously force: state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0, latched fields 0.
REQ-016 Reset mid-transaction SHALL discard the pending response; ram_we = 0 while rst is high.

Configuration
REQ-017 Macro MISALIGN_TRAP_EN defined: a half access with addr[0] = 1, or a word access with addr[1:0] != 0, SHALL produce no RAM write and a 1-cycle response with rsp_err = 1, rsp_rdata = 0.
REQ-018 MISALIGN_TRAP_EN undefined: misaligned low address bits SHALL be ignored (half uses addr[1] only; word ignores addr[1:0]), and rsp_err is raised only per REQ-013.

Structure
REQ-019 A shared package SHALL hold the size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD) and the state enum.
REQ-020 Byte-lane steering (byte enables, write replication, read shift and extend) SHALL live in one combinational sub-module, mem_lane_align.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Word store 0xDEADBEEF at byte addr 0x10, then word load from 0x10 -> ram_we 1111 on the store accept cycle; load rsp_rdata 0xDEADBEEF 2 cycles after accept.
- Byte store 0x80 at 0x13, then signed byte load from 0x13 -> ram_we 1000; rsp_rdata 0xFFFFFF80. Unsigned byte load -> 0x00000080.
- Half load from 0x12 with word 0x8001xxxx in RAM -> signed 0xFFFF8001; unsigned 0x00008001.
- Word load from 0x11 -> with MISALIGN_TRAP_EN: rsp_err 1, rsp_rdata 0, no RAM write. Without: rsp_err 0 and data from word 0x10.
- rsp_ready held low 5 cycles -> rsp_valid and rsp_rdata stay stable and req_ready stays 0; response completes on the first cycle rsp_ready is high.
- rst asserted in RD_WAIT -> rsp_valid 0 immediately; after release, state IDLE with req_ready 1 and no stale response.
